// File: rtl/z_serial_adder_ctrl_if.sv
// Request/result bundle for z_serial_adder_ctrl.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and payload is stable while valid is high.
interface z_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output req_valid, a, b, c_in, sub, res_ready,
    input  req_ready, res_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  req_valid, a, b, c_in, sub, res_ready,
    output req_ready, res_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/z_serial_adder_ctrl.sv
// Multi-cycle adder: one SLICE-bit generate/propagate ripple slice per clock, LSB first.
// Optional subtract (b inverted, carry-in forced to 1) is built when Z_ADD_SUB_EN is defined.
module z_serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int D     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  z_serial_adder_ctrl_if.slave   bus,
  output logic [1:0]             dbg_state
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_out_q, ovf_q;
  logic             accept;
  logic             last_slice;

  logic [SLICE-1:0] a_sl, b_sl, gen, prop, s_sl;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] eff_b;
  logic             eff_c;
  logic             unused_cfg;

`ifdef Z_ADD_SUB_EN
  assign eff_b      = bus.sub ? ~bus.b : bus.b;
  assign eff_c      = bus.sub ? 1'b1   : bus.c_in;
  assign unused_cfg = (D >= 0);
`else
  assign eff_b      = bus.b;
  assign eff_c      = bus.c_in;
  assign unused_cfg = (D >= 0) ^ bus.sub;
`endif

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  // Ripple through the current slice; c[0] is the carry left by the previous slice.
  always_comb begin
    a_sl = a_q[cnt_q * SLICE +: SLICE];
    b_sl = b_q[cnt_q * SLICE +: SLICE];
    gen  = a_sl & b_sl;
    prop = a_sl ^ b_sl;
    c    = '0;
    s_sl = '0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      s_sl[i]  = prop[i] ^ c[i];
      c[i + 1] = gen[i] | (prop[i] & c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= eff_b;
      carry_q <= eff_c;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[cnt_q * SLICE +: SLICE] <= s_sl;
      carry_q <= c[SLICE];
      // Counter wraps to 0 on the last slice so it never reaches NSLICE.
      cnt_q   <= last_slice ? '0 : cnt_q + 1'b1;
      if (last_slice) begin
        c_out_q <= c[SLICE];
        ovf_q   <= c[SLICE - 1] ^ c[SLICE];
      end
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_z_serial_adder_ctrl.sv
// Self-checking bench for z_serial_adder_ctrl: directed cases plus random operations
// scored against an arithmetic reference model.
module tb_z_serial_adder_ctrl;
  localparam int W      = 16;
  localparam int SL     = 4;
  localparam int NSLICE = W / SL;
`ifdef Z_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [W+1:0] exp_q[$];

  z_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  z_serial_adder_ctrl #(.WIDTH(W), .SLICE(SL), .D(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    logic         ov;
    bb = b;
    cc = cin;
    if (SUB_EN && sub) begin
      bb = ~b;
      cc = 1'b1;
    end
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // driver tasks (entered and left on a negedge)
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = cin;
    bus.sub       = sub;
    bus.req_valid = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.c_in      = 1'($urandom);
    bus.sub       = 1'($urandom);
    chk("run_busy", {31'd0, bus.busy}, 32'd1);
    chk("run_req_ready", {31'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.res_valid && n < 32) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", n, NSLICE);
  endtask

  task automatic finish_op(input int hold);
    logic [W+1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("hold_result", {14'd0, bus.ovf, bus.c_out, bus.sum}, {14'd0, e});
    end
    chk("result", {14'd0, bus.ovf, bus.c_out, bus.sum}, {14'd0, e});
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("drain_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("drain_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    accept_op(a, b, cin, sub);
    wait_result();
    finish_op(hold);
  endtask

  // stimulus
  initial begin
    logic seen_valid;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_c_out", {31'd0, bus.c_out}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("ripple_sum_const", {16'd0, bus.sum}, 32'h0000);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("ovf_sum_const", {16'd0, bus.sum}, 32'h8000);
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, 5);
    chk("bp_sum_const", {16'd0, bus.sum}, 32'h2346);

    // Abandon an operation with a mid-RUN reset.
    accept_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid) seen_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_result", {31'd0, seen_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 0);
    chk("after_abort_sum", {16'd0, bus.sum}, 32'h0005);

    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
    chk("sub_sum_const", {16'd0, bus.sum}, SUB_EN ? 32'hFFFE : 32'h000C);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
